// File: rtl/wb_rand_slave_model.sv
// Multi-channel Wishbone classic slave model with bounded random wait states and stable read data.
// Optional macro WB_ERR_INJECT_EN enables random error responses in place of acks.

module wb_rand_slave_ch #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int SW       = DW/8,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    adr,
  input  logic [DW-1:0]    dat_w,
  input  logic [SW-1:0]    sel,
  input  logic             cyc,
  input  logic             stb,
  input  logic             we,
  input  logic [DW-1:0]    rand_dat,
  input  logic             rand_ack,
  input  logic             rand_err,
  output logic [DW-1:0]    dat_r,
  output logic             ack,
  output logic             err,
  output logic             viol,
  output logic [CNT_W-1:0] xfer_cnt
);
  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          we;
  } req_t;

  state_t         state;
  req_t           cur, lat;
  logic [WCW-1:0] wait_cnt;
  logic           decide, err_now, bad;

  assign cur    = '{adr: adr, dat: dat_w, sel: sel, we: we};
  assign bad    = !cyc || !stb || (cur != lat);
  // at MAX_WAIT=0 the count is always at its limit, so rand_ack has no effect
  assign decide = rand_ack || (wait_cnt == WCW'(MAX_WAIT));

`ifdef WB_ERR_INJECT_EN
  assign err_now = rand_err;
`else
  logic unused_rand_err;
  assign unused_rand_err = rand_err;
  assign err_now = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      lat      <= '0;
      wait_cnt <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      dat_r    <= '0;
      viol     <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (cyc && stb) begin
          lat      <= cur;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bad) begin
            viol  <= 1'b1;
            state <= S_IDLE;
          end else if (decide) begin
            state <= S_RESP;
            if (err_now) begin
              err <= 1'b1;
            end else begin
              ack   <= 1'b1;
              dat_r <= lat.we ? '0 : rand_dat;
              if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        S_RESP: begin
          // a request still present here is re-sampled in IDLE
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

module wb_rand_slave_model #(
  parameter int NCH      = 2,
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int SW       = DW/8,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic [0:0]           clock,
  input  logic [0:0]           reset,
  input  logic [NCH*AW-1:0]    wb_adr,
  input  logic [NCH*DW-1:0]    wb_dat_w,
  input  logic [NCH*SW-1:0]    wb_sel,
  input  logic [NCH-1:0]       wb_cyc,
  input  logic [NCH-1:0]       wb_stb,
  input  logic [NCH-1:0]       wb_we,
  output logic [NCH*DW-1:0]    wb_dat_r,
  output logic [NCH-1:0]       wb_ack,
  output logic [NCH-1:0]       wb_err,
  input  logic [NCH*DW-1:0]    rand_dat,
  input  logic [NCH-1:0]       rand_ack,
  input  logic [NCH-1:0]       rand_err,
  output logic [NCH-1:0]       viol,
  output logic [NCH*CNT_W-1:0] xfer_cnt
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    wb_rand_slave_ch #(
      .AW(AW), .DW(DW), .SW(SW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .adr      (wb_adr[c*AW +: AW]),
      .dat_w    (wb_dat_w[c*DW +: DW]),
      .sel      (wb_sel[c*SW +: SW]),
      .cyc      (wb_cyc[c]),
      .stb      (wb_stb[c]),
      .we       (wb_we[c]),
      .rand_dat (rand_dat[c*DW +: DW]),
      .rand_ack (rand_ack[c]),
      .rand_err (rand_err[c]),
      .dat_r    (wb_dat_r[c*DW +: DW]),
      .ack      (wb_ack[c]),
      .err      (wb_err[c]),
      .viol     (viol[c]),
      .xfer_cnt (xfer_cnt[c*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_wb_rand_slave_model.sv
// Directed bench for wb_rand_slave_model: two-channel DUT (MAX_WAIT=3, CNT_W=2) plus a one-channel MAX_WAIT=0 DUT.

module tb_wb_rand_slave_model;
  localparam int NCH = 2, AW = 30, DW = 32, SW = 4, CW = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [NCH*AW-1:0]   wb_adr;
  logic [NCH*DW-1:0]   wb_dat_w, wb_dat_r, rand_dat;
  logic [NCH*SW-1:0]   wb_sel;
  logic [NCH-1:0]      wb_cyc, wb_stb, wb_we, wb_ack, wb_err, rand_ack, rand_err, viol;
  logic [NCH*CW-1:0]   xfer_cnt;

  logic [AW-1:0] z_adr;
  logic [DW-1:0] z_dat_w, z_dat_r, z_rdat;
  logic [SW-1:0] z_sel;
  logic          z_cyc, z_stb, z_we, z_ack, z_err, z_rack, z_rerr, z_viol;
  logic [15:0]   z_cnt;

  int errs = 0, nchk = 0;

  always #5 clock = ~clock;

  wb_rand_slave_model #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_WAIT(3), .CNT_W(CW)) u_dut (
    .clock(clock), .reset(reset), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
    .wb_err(wb_err), .rand_dat(rand_dat), .rand_ack(rand_ack), .rand_err(rand_err),
    .viol(viol), .xfer_cnt(xfer_cnt));

  wb_rand_slave_model #(.NCH(1), .AW(AW), .DW(DW), .MAX_WAIT(0), .CNT_W(16)) u_z (
    .clock(clock), .reset(reset), .wb_adr(z_adr), .wb_dat_w(z_dat_w), .wb_sel(z_sel),
    .wb_cyc(z_cyc), .wb_stb(z_stb), .wb_we(z_we), .wb_dat_r(z_dat_r), .wb_ack(z_ack),
    .wb_err(z_err), .rand_dat(z_rdat), .rand_ack(z_rack), .rand_err(z_rerr),
    .viol(z_viol), .xfer_cnt(z_cnt));

  typedef struct {
    logic        req;
    logic [31:0] rdat;
    logic        e_ack;
    logic [31:0] e_dat;
    logic [1:0]  e_cnt;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int ch, input logic r, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_cyc[ch] = r;
    wb_stb[ch] = r;
    wb_we[ch]  = we;
    wb_adr[ch*AW +: AW] = a;
    wb_dat_w[ch*DW +: DW] = d;
    wb_sel[ch*SW +: SW] = 4'hF;
  endtask

  initial begin
    reset = 1'b1;
    wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_cyc = '0; wb_stb = '0; wb_we = '0;
    rand_dat = '0; rand_ack = '0; rand_err = '0;
    z_adr = '0; z_dat_w = '0; z_sel = '0; z_cyc = 0; z_stb = 0; z_we = 0;
    z_rdat = '0; z_rack = 0; z_rerr = 0;
    tick(); tick();
    reset = 1'b0;

    // reset: fast transfer, then reset for 2 cycles while ch0 is in WAIT
    set_req(0, 1, 0, 30'h100, 0); rand_ack[0] = 1; rand_dat[31:0] = 32'hA5A5A5A5;
    tick(); tick();
    chk("pre_rst_ack", wb_ack[0], 1);
    chk("pre_rst_cnt", xfer_cnt[1:0], 1);
    set_req(0, 0, 0, 30'h100, 0);
    tick();
    set_req(0, 1, 0, 30'h100, 0); rand_ack[0] = 0;
    tick(); tick();
    reset = 1; rand_ack[0] = 1;
    tick(); tick();
    reset = 0;
    chk("rst_ack", wb_ack[0], 0);
    chk("rst_err", wb_err[0], 0);
    chk("rst_viol", viol[0], 0);
    chk("rst_cnt", xfer_cnt[1:0], 0);
    chk("rst_dat", wb_dat_r[31:0], 0);
    tick();
    chk("post_rst_c1_ack", wb_ack[0], 0);
    tick();
    chk("post_rst_c2_ack", wb_ack[0], 1);
    set_req(0, 0, 0, 30'h100, 0); rand_ack[0] = 0;
    tick();

    // read with full wait, table driven; dat_r must hold after RESP
    tbl[0] = '{1, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1};
    tbl[1] = '{1, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1};
    tbl[2] = '{1, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1};
    tbl[3] = '{1, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1};
    tbl[4] = '{1, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1};
    tbl[5] = '{1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 2};
    tbl[6] = '{0, 32'h11111111, 0, 32'hDEADBEEF, 2};
    tbl[7] = '{0, 32'h11111111, 0, 32'hDEADBEEF, 2};
    for (int i = 0; i < 8; i++) begin
      set_req(0, tbl[i].req, 0, 30'h100, 0);
      rand_dat[31:0] = tbl[i].rdat;
      chk($sformatf("rd%0d_ack", i), wb_ack[0], tbl[i].e_ack);
      chk($sformatf("rd%0d_dat", i), wb_dat_r[31:0], tbl[i].e_dat);
      chk($sformatf("rd%0d_cnt", i), xfer_cnt[1:0], tbl[i].e_cnt);
      chk($sformatf("rd%0d_ch1_ack", i), wb_ack[1], 0);
      tick();
    end

    // fast write on ch1
    set_req(1, 1, 1, 30'h40, 32'h12345678); rand_ack[1] = 1; rand_dat[63:32] = 32'hCAFEF00D;
    tick();
    chk("wr_c1_ack", wb_ack[1], 0);
    tick();
    chk("wr_ack", wb_ack[1], 1);
    chk("wr_dat", wb_dat_r[63:32], 0);
    chk("wr_cnt1", xfer_cnt[3:2], 1);
    chk("wr_ch0_ack", wb_ack[0], 0);
    chk("wr_ch0_cnt", xfer_cnt[1:0], 2);
    set_req(1, 0, 0, 30'h40, 0); rand_ack[1] = 0;
    tick();

    // violation: address changes while waiting
    set_req(0, 1, 0, 30'h100, 0);
    tick(); tick();
    set_req(0, 1, 0, 30'h104, 0);
    chk("vio_c2_ack", wb_ack[0], 0);
    tick();
    chk("vio_flag", viol[0], 1);
    chk("vio_c3_ack", wb_ack[0], 0);
    tick();
    rand_ack[0] = 1;
    chk("vio_c4_ack", wb_ack[0], 0);
    tick();
    chk("vio_next_ack", wb_ack[0], 1);
    chk("vio_next_cnt", xfer_cnt[1:0], 3);
    set_req(0, 0, 0, 30'h104, 0); rand_ack[0] = 0;
    tick();
    chk("vio_sticky", viol[0], 1);
    chk("vio_ack_drop", wb_ack[0], 0);

    // saturation: 5 back-to-back acked reads with CNT_W=2
    reset = 1; tick(); reset = 0;
    set_req(0, 1, 0, 30'h200, 0); rand_ack[0] = 1; rand_dat[31:0] = 32'h0BADF00D;
    for (int k = 0; k < 15; k++) begin
      int exp_cnt;
      exp_cnt = (k + 1) / 3;
      if (exp_cnt > 3) exp_cnt = 3;
      chk($sformatf("sat%0d_ack", k), wb_ack[0], (k % 3 == 2) ? 1 : 0);
      chk($sformatf("sat%0d_cnt", k), xfer_cnt[1:0], exp_cnt[1:0]);
      chk($sformatf("sat%0d_both", k), wb_ack[0] & wb_err[0], 0);
      tick();
    end
    set_req(0, 0, 0, 30'h200, 0); rand_ack[0] = 0;
    tick();
    chk("sat_hold", xfer_cnt[1:0], 3);

    // error injection (or plain ack when the macro is off) on ch1
    set_req(1, 1, 0, 30'h44, 0); rand_ack[1] = 1; rand_err[1] = 1; rand_dat[63:32] = 32'h77777777;
    tick();
    chk("err_c1_err", wb_err[1], 0);
    tick();
`ifdef WB_ERR_INJECT_EN
    chk("err_err", wb_err[1], 1);
    chk("err_ack", wb_ack[1], 0);
    chk("err_cnt", xfer_cnt[3:2], 0);
    chk("err_dat", wb_dat_r[63:32], 0);
`else
    chk("err_err", wb_err[1], 0);
    chk("err_ack", wb_ack[1], 1);
    chk("err_cnt", xfer_cnt[3:2], 1);
    chk("err_dat", wb_dat_r[63:32], 32'h77777777);
`endif
    set_req(1, 0, 0, 30'h44, 0); rand_ack[1] = 0; rand_err[1] = 0;
    tick();
    chk("err_drop_err", wb_err[1], 0);
    chk("err_drop_ack", wb_ack[1], 0);

    // MAX_WAIT=0: ack exactly two cycles after the request, rand_ack irrelevant
    for (int r = 0; r < 2; r++) begin
      z_cyc = 1; z_stb = 1; z_adr = 30'h10; z_sel = 4'hF;
      z_rack = r[0]; z_rdat = 32'h5000_0000 + r;
      tick();
      chk($sformatf("mw0_%0d_c1", r), z_ack, 0);
      tick();
      chk($sformatf("mw0_%0d_ack", r), z_ack, 1);
      chk($sformatf("mw0_%0d_dat", r), z_dat_r, 32'h5000_0000 + r);
      z_cyc = 0; z_stb = 0;
      tick();
    end
    chk("mw0_cnt", z_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/wb_rand_slave_model.md
Name: wb_rand_slave_model

Overview:
- Parametrised, multi-channel Wishbone classic slave model for the formal and simulation harnesses around rv32_cpu.
- Replaces the ad-hoc per-bus random ack/data nets with a real per-channel transaction FSM:
  - bounded wait states, so liveness is guaranteed;
  - response data held stable;
  - sticky master-protocol-violation detection;
  - per-channel transfer counters.
- Channel 0 serves ibus and channel 1 serves dbus; NCH generalises this to any number of masters.

Parameters:
- NCH, 2, number of independent Wishbone slave channels.
- AW, 30, word address width.
- DW, 32, data width; SW = DW/8 is the select width.
- MAX_WAIT, 3, maximum WAIT cycles before ack is forced (0 allowed).
- CNT_W, 16, width of the per-channel saturating transfer counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wb_adr  in  NCH*AW  master address; channel c occupies slice [c*AW +: AW].
- wb_dat_w  in  NCH*DW  master write data.
- wb_sel  in  NCH*SW  byte selects.
- wb_cyc  in  NCH  cycle valid.
- wb_stb  in  NCH  strobe.
- wb_we  in  NCH  write enable.
- wb_dat_r  out  NCH*DW  read data.
- wb_ack  out  NCH  transfer acknowledge.
- wb_err  out  NCH  error response (tied 0 unless WB_ERR_INJECT_EN).
- rand_dat  in  NCH*DW  free random read data, from rvformal_rand_reg in the harness.
- rand_ack  in  NCH  free random "ack now" request.
- rand_err  in  NCH  free random "respond with error" request.
- viol  out  NCH  sticky protocol-violation flag.
- xfer_cnt  out  NCH*CNT_W  completed-ack counter.

Behaviour:
- Channels are fully independent; the description below applies per channel c.
- Reset (synchronous, while reset=1):
  - state=IDLE; wb_ack=0, wb_err=0, wb_dat_r=0, viol=0, xfer_cnt=0; wait counter=0.
  - Reset mid-transfer abandons the transfer with no response.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On cyc&stb, latch adr/we/sel/dat_w, set wait_cnt=0, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, evaluated every cycle:
  - Violation: cyc=0, stb=0, or any of adr/we/sel/dat_w differing from the latched value. Action: set viol, go to IDLE, no response.
  - Otherwise, if rand_ack=1 or wait_cnt==MAX_WAIT: go to RESP, registering:
    - wb_ack=1;
    - wb_dat_r = rand_dat for reads, 0 for writes.
  - Otherwise: wait_cnt+1, stay in WAIT.
  - Violation takes priority over response.
- RESP:
  - wb_ack (or wb_err) is high for exactly this one cycle; next state is IDLE.
  - A request still present in the RESP cycle is not a new request; it is sampled again in IDLE.
- Outputs after RESP:
  - wb_ack/wb_err return to 0 in the following cycle.
  - wb_dat_r holds its value until the next RESP (stable-data guarantee).
- Latency:
  - Request first seen in cycle N (IDLE); ack is visible in cycle N+2 at the earliest and N+2+MAX_WAIT at the latest.
  - Maximum throughput is one transfer per 3 cycles per channel.
- MAX_WAIT=0: ack is always exactly at N+2, and rand_ack is ignored.
- xfer_cnt:
  - Increments on the clock edge that enters RESP with ack.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Error responses are not counted.
- viol is sticky until reset and does not block later transfers.
- wb_ack and wb_err are never both 1.

Optional Feature:
- Macro: WB_ERR_INJECT_EN.
- When defined, a WAIT decision with rand_err=1 enters RESP with:
  - wb_err=1, wb_ack=0;
  - wb_dat_r unchanged;
  - xfer_cnt not incremented.
- An error decision also happens when wait_cnt==MAX_WAIT and rand_err=1.
- When undefined:
  - wb_err is constant 0 and rand_err is unused.
  - The channel can only complete with ack.

Test Plan:
- Reset: hold reset 2 cycles mid-WAIT on ch0 -> ack=0, err=0, viol=0, xfer_cnt=0, state IDLE next cycle.
- Read, MAX_WAIT=3, rand_ack=0 throughout:
  - Stimulus: ch0 cyc=stb=1, we=0, adr=0x100 from cycle 0; rand_dat=0xDEADBEEF.
  - Response: ack only in cycle 5; dat_r=0xDEADBEEF held afterwards; xfer_cnt=1.
- Fast write: ch1 we=1, dat_w=0x12345678, rand_ack=1 -> ack in cycle 2, dat_r=0, xfer_cnt[1]=1; ch0 unaffected.
- Violation:
  - Stimulus: change ch0 adr 0x100 -> 0x104 in cycle 2 while waiting.
  - Response: viol[0]=1 sticky, no ack; a following clean request is still acked.
- Saturation: CNT_W=2, 5 back-to-back acked reads -> xfer_cnt=3, stays 3.
- WB_ERR_INJECT_EN defined, rand_err=1, rand_ack=1 -> err=1, ack=0 for one cycle, xfer_cnt unchanged; with the macro undefined, the same stimulus gives ack=1.
